dmem_waitstate: RTL and testbench
=================================

# dmem_waitstate

Parametrised data-memory block for the 5-stage RV32I pipeline. It replaces the single-cycle data memory with a request/response slave that has configurable access latency, full RV32I load/store sizing from `funct3`, and error signalling for misaligned, out-of-range and illegal accesses. It sits between the MEM stage of the core and the storage array, and drives `busy` so the core can freeze the pipeline while an access is outstanding.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, at least 4.
- `LATENCY`, default 2: wait cycles between accept and access; range 0..15.
- `clk`  in  1  clock; rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  a request is presented.
- `req_ready`  out  1  the block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_funct3`  in  3  RV32I access size and sign.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `rsp_err`  out  1  the access was rejected; qualified by `rsp_valid`.
- `busy`  out  1  an access is outstanding; the core stalls on it.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - Accept when `req_valid`=1. Capture write, addr, wdata and funct3.
  - Decode the request (see checks below).
  - If the check fails: go to RESP with err=1. No array access.
  - Else, if `LATENCY`=0: do the access in the accept cycle, then go to RESP.
  - Else: load the counter with `LATENCY`-1 and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0: do the access and go to RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
  - No request is accepted in RESP (back-to-back throughput is one access per `LATENCY`+2 cycles).
- **Access checks**
  - Legal load `funct3`: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store `funct3`: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and sets err.
  - Misaligned (sets err): halfword with addr[0]=1; word with addr[1:0]≠0.
  - Out of range (sets err): addr ≥ 4·`DEPTH_WORDS`.
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
- **Stores**
  - Byte-lane write enable only. Unselected bytes are left unchanged.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0}..+1 get wdata[15:0].
- **Loads**
  - Read the word, select the byte or halfword by lane, then extend.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Reset**
  - The array is not reset; contents are undefined until written.
  - Reset forces IDLE and clears the counter and captured registers.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
- Accept at edge N gives `rsp_valid` high during cycle N+`LATENCY`+1.
- Error responses come at N+1, regardless of `LATENCY`.
- A store commits at the edge that enters RESP. A load in the next request observes it.
- `rsp_rdata` and `rsp_err` are registered, valid only while `rsp_valid`=1, and 0 otherwise.
- Request inputs are sampled only at the accept edge. Later changes are ignored.
- Reset asserted mid-WAIT: the pending store is discarded (array unchanged), no response is produced, and the block is ready the cycle after deassertion.
- `req_valid` held high through RESP: it is accepted on the first IDLE cycle, with no double-accept.

## Structure
- Package `dmem_pkg`:
  - funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State enum {IDLE, WAIT, RESP}.
  - Function `is_legal(write, funct3)`.
- Sub-module `dmem_lane_align` (combinational), two parts:
  - Store side: addr[1:0], funct3 and wdata in; 4-bit byte enable and lane-shifted data out.
  - Load side: the read word in; extended result out.
- Top: FSM, counter, capture registers, array.

## Test plan
- `LATENCY`=2: SW 0xDEADBEEF @0x10, then LW @0x10 → each `rsp_valid` at accept+3, LW data 0xDEADBEEF, err=0, `busy` high for 3 cycles per access.
- Over word 0x11223344 @0x20: SB 0xAA @0x21 then LW → 0x1122AA44. LB @0x21 → 0xFFFFFFAA; LBU → 0x000000AA. SH 0x8001 @0x22 then LH → 0xFFFF8001; LHU → 0x00008001.
- LW @0x02, LH @0x01, funct3=011, and addr 4·`DEPTH_WORDS` → err=1 at accept+1, `rsp_rdata`=0, target words unchanged.
- `LATENCY`=0: SW then LW back-to-back with `req_valid` held high → accepts 2 cycles apart, correct data, no double-accept.
- Reset pulse one cycle after accepting SW 0x55 @0x40 → no `rsp_valid`, LW @0x40 returns the prior contents, all outputs at reset values during reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory: RV32I load/store
// size codes, the controller state type and the request legality check.
package dmem_pkg;

  // RV32I funct3 codes for loads
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // RV32I funct3 codes for stores
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when funct3 names a real RV32I access of the given direction.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    end
    return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit storage word and the core's
// right-aligned data: store side builds byte enables and replicated write
// data, load side picks the addressed byte/halfword and extends it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_lane,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lane,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] ld_data
);

  logic [7:0]  word_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the read word into its four byte lanes
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_bytes[gi] = ld_word[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = word_bytes[ld_lane];
  assign half_sel = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

  // Store side: replicate the data across lanes, enable only the addressed ones
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (st_funct3)
      SB: begin
        st_be   = 4'b0001 << st_lane;
        st_data = {4{st_wdata[7:0]}};
      end
      SH: begin
        st_be   = st_lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      SW: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
      default: ;
    endcase
  end

  // Load side: sign- or zero-extend the selected byte/halfword
  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      LB:      ld_data = {{24{byte_sel[7]}}, byte_sel};
      LH:      ld_data = {{16{half_sel[15]}}, half_sel};
      LW:      ld_data = ld_word;
      LBU:     ld_data = {24'h0, byte_sel};
      LHU:     ld_data = {16'h0, half_sel};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_waitstate.sv
// Request/response data memory with a programmable number of wait cycles.
// Illegal, misaligned and out-of-range requests are answered immediately
// with rsp_err and never touch the array.
module dmem_waitstate
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic       ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        write_reg, write_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        err_reg, err_next;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_reg;

  logic        req_misaligned, req_oor, req_err;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_funct3;
  logic [AW-1:0] acc_idx;
  logic        access_fire, mem_we, mem_re;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  // Request decode is done on the live inputs during the accept cycle
  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_oor        = (req_addr[31:AW+2] != '0);
  assign req_err        = !is_legal(req_write, req_funct3) || req_misaligned || req_oor;

  // Zero-latency accesses use the inputs directly; otherwise the captured copy
  assign acc_write  = (state_reg == IDLE) ? req_write  : write_reg;
  assign acc_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign acc_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign acc_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
  assign acc_idx    = acc_addr[AW+1:2];

  assign access_fire = (ZERO_LAT && (state_reg == IDLE) && req_valid && !req_err) ||
                       ((state_reg == WAIT) && (cnt_reg == 4'd0));
  assign mem_we      = access_fire && acc_write;
  assign mem_re      = access_fire && !acc_write;

  dmem_lane_align u_align (
    .st_lane   (acc_addr[1:0]),
    .st_funct3 (acc_funct3),
    .st_wdata  (acc_wdata),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_word   (rd_word_reg),
    .ld_lane   (addr_reg[1:0]),
    .ld_funct3 (funct3_reg),
    .ld_data   (ld_data)
  );

  // Next-state, counter and capture logic
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    write_next  = write_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    funct3_next = funct3_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          write_next  = req_write;
          addr_next   = req_addr;
          wdata_next  = req_wdata;
          funct3_next = req_funct3;
          err_next    = req_err;
          if (req_err || ZERO_LAT) begin
            state_next = RESP;
          end else begin
            cnt_next   = LAT_LOAD;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Controller registers; reset abandons any outstanding access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      write_reg  <= 1'b0;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      funct3_reg <= 3'b000;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      funct3_reg <= funct3_next;
      err_reg    <= err_next;
    end
  end

  // Storage array: byte-lane writes and registered read, never reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[acc_idx][b*8 +: 8] <= st_data[b*8 +: 8];
        end
      end
    end
    if (mem_re) begin
      rd_word_reg <= mem[acc_idx];
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_valid && err_reg;
  assign rsp_rdata = (rsp_valid && !err_reg && !write_reg) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_waitstate.sv
// Bench for dmem_waitstate: one instance with two wait cycles, one with
// none, both checked against a byte-addressed reference memory.
module tb_dmem_waitstate;

  localparam int DEPTH = 64;
  localparam int NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_write = '0;
  logic [1:0][31:0]  req_addr = '0;
  logic [1:0][31:0]  req_wdata = '0;
  logic [1:0][2:0]   req_funct3 = '0;
  logic [1:0]        rsp_valid;
  logic [1:0][31:0]  rsp_rdata;
  logic [1:0]        rsp_err;
  logic [1:0]        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [2][NBYTES];

  always #5 clk = ~clk;

  dmem_waitstate #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0])
  );

  dmem_waitstate #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference: byte-addressed memory, sizes 1/2/4, little-endian
  task automatic model_access(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              output bit err, output logic [31:0] rdata);
    int size;
    bit legal;
    logic [31:0] val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || (addr % size != 0) || (addr >= NBYTES);
    rdata = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) ref_mem[d][addr + i] = wdata[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | (32'(ref_mem[d][addr + i]) << (8*i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFFFFFF << (8*size));
        rdata = val;
      end
    end
  endtask

  // One full transaction with latency, busy, response and idle-after checks
  task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er);
    bit exp_err;
    logic [31:0] exp_rd;
    int exp_k, k, busy_n;
    bit seen;
    model_access(d, wr, addr, wdata, f3, exp_err, exp_rd);
    exp_k = exp_err ? 1 : lat_of(d) + 1;
    rd = 32'h0;
    er = 1'b0;
    @(negedge clk);
    req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
    req_funct3[d] = f3; req_valid[d] = 1'b1;
    check($sformatf("d%0d ready_before_accept", d), 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_funct3[d] = 3'($urandom);
    seen = 0; k = 0; busy_n = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (busy[d]) busy_n++;
      if (rsp_valid[d]) begin
        seen = 1; k = c; rd = rsp_rdata[d]; er = rsp_err[d];
      end
    end
    check($sformatf("d%0d rsp_seen a=%h", d, addr), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("d%0d rsp_latency a=%h", d, addr), 32'(k), 32'(exp_k));
      check($sformatf("d%0d busy_cycles a=%h", d, addr), 32'(busy_n), 32'(exp_k));
      check($sformatf("d%0d rsp_err a=%h f3=%0d", d, addr, f3), 32'(er), 32'(exp_err));
      check($sformatf("d%0d rsp_rdata a=%h f3=%0d", d, addr, f3), rd, exp_rd);
    end
    @(negedge clk);
    check($sformatf("d%0d rsp_one_cycle", d), 32'(rsp_valid[d]), 32'd0);
    check($sformatf("d%0d idle_after", d), {busy[d], rsp_err[d]}, 32'd0);
    check($sformatf("d%0d rdata_zero_idle", d), rsp_rdata[d], 32'h0);
    $display("txn d%0d wr=%0d f3=%0d addr=%08h wdata=%08h -> err=%0d rdata=%08h lat=%0d",
             d, wr, f3, addr, wdata, er, rd, k);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d req_ready", tag, d), 32'(req_ready[d]), 32'd1);
      check($sformatf("%s d%0d rsp_valid", tag, d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("%s d%0d rsp_rdata", tag, d), rsp_rdata[d], 32'h0);
      check($sformatf("%s d%0d rsp_err", tag, d), 32'(rsp_err[d]), 32'd0);
      check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd, prior, addr;
    logic er;
    bit mer;
    logic [31:0] mrd;
    int r;

    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Fill both arrays so every later load has defined contents
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        do_req(d, 1'b1, 32'(w * 4), $urandom, 3'b010, rd, er);

    // Directed word/byte/halfword cases on the two-wait-cycle instance
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
    do_req(0, 0, 32'h10, 32'h0, 3'b010, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    do_req(0, 1, 32'h20, 32'h11223344, 3'b010, rd, er);
    do_req(0, 1, 32'h21, 32'h000000AA, 3'b000, rd, er);
    do_req(0, 0, 32'h20, 32'h0, 3'b010, rd, er);
    check("sb_merge", rd, 32'h1122AA44);
    do_req(0, 0, 32'h21, 32'h0, 3'b000, rd, er);
    check("lb_sign", rd, 32'hFFFFFFAA);
    do_req(0, 0, 32'h21, 32'h0, 3'b100, rd, er);
    check("lbu_zero", rd, 32'h000000AA);
    do_req(0, 1, 32'h22, 32'h00008001, 3'b001, rd, er);
    do_req(0, 0, 32'h22, 32'h0, 3'b001, rd, er);
    check("lh_sign", rd, 32'hFFFF8001);
    do_req(0, 0, 32'h22, 32'h0, 3'b101, rd, er);
    check("lhu_zero", rd, 32'h00008001);

    // Rejected requests: answered at once, array untouched
    do_req(0, 0, 32'h02, 32'h0, 3'b010, rd, er);
    check("err_lw_misaligned", 32'(er), 32'd1);
    do_req(0, 0, 32'h01, 32'h0, 3'b001, rd, er);
    check("err_lh_misaligned", 32'(er), 32'd1);
    do_req(0, 1, 32'h20, 32'hFFFFFFFF, 3'b011, rd, er);
    check("err_f3_011", 32'(er), 32'd1);
    do_req(0, 1, 32'(NBYTES), 32'hFFFFFFFF, 3'b010, rd, er);
    check("err_out_of_range", 32'(er), 32'd1);
    do_req(0, 1, 32'h12, 32'h0BADF00D, 3'b010, rd, er);
    check("err_sw_misaligned", 32'(er), 32'd1);
    do_req(0, 0, 32'h10, 32'h0, 3'b010, rd, er);
    check("unchanged_0x10", rd, 32'hDEADBEEF);
    do_req(0, 0, 32'h20, 32'h0, 3'b010, rd, er);
    check("unchanged_0x20", rd, 32'h8001AA44);

    // Zero latency, back-to-back with req_valid held high
    @(negedge clk);
    req_write[1] = 1; req_addr[1] = 32'h30; req_wdata[1] = 32'hCAFEF00D;
    req_funct3[1] = 3'b010; req_valid[1] = 1;
    @(posedge clk);
    #1;
    req_write[1] = 0; req_wdata[1] = 32'h0;
    @(negedge clk);
    check("b2b sw_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("b2b ready_in_resp", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    check("b2b idle_ready", 32'(req_ready[1]), 32'd1);
    check("b2b no_rsp_idle", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk);
    #1;
    req_valid[1] = 0;
    @(negedge clk);
    check("b2b lw_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("b2b lw_data", rsp_rdata[1], 32'hCAFEF00D);
    @(negedge clk);
    check("b2b no_double_accept", {busy[1], rsp_valid[1]}, 32'd0);
    model_access(1, 1, 32'h30, 32'hCAFEF00D, 3'b010, mer, mrd);
    $display("txn d1 back-to-back SW/LW @00000030 done");

    // Reset mid-wait discards the pending store
    prior = {ref_mem[0][32'h43], ref_mem[0][32'h42], ref_mem[0][32'h41], ref_mem[0][32'h40]};
    @(negedge clk);
    req_write[0] = 1; req_addr[0] = 32'h40; req_wdata[0] = 32'h55;
    req_funct3[0] = 3'b010; req_valid[0] = 1;
    @(posedge clk);
    #1;
    req_valid[0] = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midwait_rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst ready", 32'(req_ready[0]), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("post_rst no_rsp", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    do_req(0, 0, 32'h40, 32'h0, 3'b010, rd, er);
    check("store_discarded", rd, prior);

    // Randomised traffic on both instances
    for (int i = 0; i < 150; i++) begin
      for (int d = 0; d < 2; d++) begin
        r = $urandom_range(0, 9);
        if (r == 0) addr = $urandom;
        else if (r == 1) addr = 32'(NBYTES + $urandom_range(0, 15));
        else addr = 32'($urandom_range(0, NBYTES - 1));
        do_req(d, 1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)), rd, er);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
